// File: rtl/pagerank_pkg.sv
// Shared types and constants for the PageRank vector loader: FSM states,
// memory message layouts (type|opaque|addr|len|data) and their pack helpers.
package pagerank_pkg;

    localparam int NWORDS_DEFAULT = 8;
    // Word counts and received counters never exceed 256.
    localparam int CNT_W = 9;

    localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
    localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_msg_t;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_msg_t;

    function automatic mem_req_msg_t mem_req_pack(
        input logic [2:0]  typ,
        input logic [7:0]  opaque,
        input logic [31:0] addr,
        input logic [1:0]  len,
        input logic [31:0] data
    );
        mem_req_msg_t m;
        m.typ    = typ;
        m.opaque = opaque;
        m.addr   = addr;
        m.len    = len;
        m.data   = data;
        return m;
    endfunction

    function automatic mem_resp_msg_t mem_resp_pack(
        input logic [2:0]  typ,
        input logic [7:0]  opaque,
        input logic [1:0]  len,
        input logic [31:0] data
    );
        mem_resp_msg_t m;
        m.typ    = typ;
        m.opaque = opaque;
        m.len    = len;
        m.data   = data;
        return m;
    endfunction

endpackage

// File: rtl/pagerank_vec_loader_if.sv
// Scheduler command/done handshake plus both memory ports of the vector loader.
// master = the loader itself, slave = scheduler and memory side.
interface pagerank_vec_loader_if
    import pagerank_pkg::*;
#(
    parameter int NWORDS = NWORDS_DEFAULT,
    parameter int nbits  = 32
);
    logic                    cmd_val;
    logic                    cmd_rdy;
    logic [31:0]             cmd_base;
    logic [31:0]             cmd_count;
    logic                    done_val;
    logic                    done_rdy;
    logic [NWORDS*nbits-1:0] vec_data;

    mem_req_msg_t            mem_req0_msg;
    logic                    mem_req0_val;
    logic                    mem_req0_rdy;
    mem_resp_msg_t           mem_resp0_msg;
    logic                    mem_resp0_val;
    logic                    mem_resp0_rdy;

    mem_req_msg_t            mem_req1_msg;
    logic                    mem_req1_val;
    logic                    mem_req1_rdy;
    mem_resp_msg_t           mem_resp1_msg;
    logic                    mem_resp1_val;
    logic                    mem_resp1_rdy;

    modport master (
        input  cmd_val, cmd_base, cmd_count, done_rdy,
        input  mem_req0_rdy, mem_resp0_msg, mem_resp0_val,
        input  mem_req1_rdy, mem_resp1_msg, mem_resp1_val,
        output cmd_rdy, done_val, vec_data,
        output mem_req0_msg, mem_req0_val, mem_resp0_rdy,
        output mem_req1_msg, mem_req1_val, mem_resp1_rdy
    );

    modport slave (
        output cmd_val, cmd_base, cmd_count, done_rdy,
        output mem_req0_rdy, mem_resp0_msg, mem_resp0_val,
        output mem_req1_rdy, mem_resp1_msg, mem_resp1_val,
        input  cmd_rdy, done_val, vec_data,
        input  mem_req0_msg, mem_req0_val, mem_resp0_rdy,
        input  mem_req1_msg, mem_req1_val, mem_resp1_rdy
    );

endinterface

// File: rtl/pagerank_loader_port.sv
// One memory port of the vector loader: issues read requests for word indices
// START, START+STRIDE, ... below the effective count.
module pagerank_loader_port
    import pagerank_pkg::*;
#(
    parameter int START  = 0,
    parameter int STRIDE = 2
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_active,
    input  logic [31:0]      i_base,
    input  logic [CNT_W-1:0] i_count,
    output mem_req_msg_t     o_req_msg,
    output logic             o_req_val,
    input  logic             i_req_rdy
);
    localparam int IW = CNT_W + 1;

    logic [CNT_W-1:0] r_issued;
    logic [IW-1:0]    w_idx;

    // One extra bit so the last index plus stride cannot wrap below the count.
    assign w_idx     = IW'(START) + IW'(STRIDE) * {1'b0, r_issued};
    assign o_req_val = i_active && (w_idx < {1'b0, i_count});
    assign o_req_msg = mem_req_pack(MEM_TYPE_READ, w_idx[7:0],
                                    i_base + (32'(w_idx) << 2), 2'd0, 32'd0);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_issued <= '0;
        end else if (i_clear) begin
            r_issued <= '0;
        end else if (o_req_val && i_req_rdy) begin
            r_issued <= r_issued + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pagerank_vec_loader.sv
// Bulk vector loader: fetches min(count, NWORDS) words over two memory ports
// (even/odd indices) into a register vector. Optional perf counter: PAGERANK_LOADER_PERF_EN.
module pagerank_vec_loader
    import pagerank_pkg::*;
#(
    parameter int NWORDS = NWORDS_DEFAULT,
    parameter int nbits  = 32
)(
    input  logic                  clk,
    input  logic                  reset,
`ifdef PAGERANK_LOADER_PERF_EN
    output logic [31:0]           perf_cycles,
`endif
    pagerank_vec_loader_if.master ifc
);
    state_t                         r_state;
    state_t                         w_state_next;
    logic [31:0]                    r_base;
    logic [CNT_W-1:0]               r_count;
    logic [CNT_W-1:0]               r_recv;
    logic [NWORDS-1:0][nbits-1:0]   r_vec;

    logic                           w_cmd_fire;
    logic                           w_load;
    logic                           w_hit0;
    logic                           w_hit1;
    logic [CNT_W-1:0]               w_eff_count;
    logic [CNT_W-1:0]               w_recv_next;

    assign w_load      = (r_state == LOAD);
    assign w_eff_count = (ifc.cmd_count > 32'(NWORDS)) ? CNT_W'(NWORDS)
                                                       : ifc.cmd_count[CNT_W-1:0];

    // Responses outside the requested range are consumed but neither stored nor counted.
    assign w_hit0      = w_load && ifc.mem_resp0_val && ({1'b0, ifc.mem_resp0_msg.opaque} < r_count);
    assign w_hit1      = w_load && ifc.mem_resp1_val && ({1'b0, ifc.mem_resp1_msg.opaque} < r_count);
    assign w_recv_next = r_recv + CNT_W'(w_hit0) + CNT_W'(w_hit1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_next      = r_state;
        w_cmd_fire        = 1'b0;
        ifc.cmd_rdy       = 1'b0;
        ifc.done_val      = 1'b0;
        ifc.mem_resp0_rdy = 1'b0;
        ifc.mem_resp1_rdy = 1'b0;
        case (r_state)
            IDLE: begin
                ifc.cmd_rdy = 1'b1;
                if (ifc.cmd_val) begin
                    w_cmd_fire   = 1'b1;
                    w_state_next = (w_eff_count == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                ifc.mem_resp0_rdy = 1'b1;
                ifc.mem_resp1_rdy = 1'b1;
                if (w_recv_next == r_count) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                ifc.done_val = 1'b1;
                if (ifc.done_rdy) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: the vector is a flop-based register file, not a RAM macro, so it
    // is reset; a zero vector after reset is visible to the scheduler.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_base  <= '0;
            r_count <= '0;
            r_recv  <= '0;
            r_vec   <= '0;
        end else if (w_cmd_fire) begin
            r_base  <= ifc.cmd_base;
            r_count <= w_eff_count;
            r_recv  <= '0;
            r_vec   <= '0;
        end else if (w_load) begin
            r_recv <= w_recv_next;
            for (int i = 0; i < NWORDS; i++) begin
                if (w_hit0 && ifc.mem_resp0_msg.opaque == 8'(i)) begin
                    r_vec[i] <= ifc.mem_resp0_msg.data;
                end
                if (w_hit1 && ifc.mem_resp1_msg.opaque == 8'(i)) begin
                    r_vec[i] <= ifc.mem_resp1_msg.data;
                end
            end
        end
    end

    assign ifc.vec_data = r_vec;

    pagerank_loader_port #(.START(0), .STRIDE(2)) u_port0 (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_cmd_fire),
        .i_active  (w_load),
        .i_base    (r_base),
        .i_count   (r_count),
        .o_req_msg (ifc.mem_req0_msg),
        .o_req_val (ifc.mem_req0_val),
        .i_req_rdy (ifc.mem_req0_rdy)
    );

    pagerank_loader_port #(.START(1), .STRIDE(2)) u_port1 (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_cmd_fire),
        .i_active  (w_load),
        .i_base    (r_base),
        .i_count   (r_count),
        .o_req_msg (ifc.mem_req1_msg),
        .o_req_val (ifc.mem_req1_val),
        .i_req_rdy (ifc.mem_req1_rdy)
    );

`ifdef PAGERANK_LOADER_PERF_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf <= '0;
        end else if (w_cmd_fire) begin
            r_perf <= '0;
        end else if (w_load) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_pagerank_vec_loader.sv
// Randomized bench for pagerank_vec_loader: a two-port memory with random
// latency/backpressure, and a reference vector computed from memory contents.
module tb_pagerank_vec_loader;
    import pagerank_pkg::*;

    localparam int NW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pagerank_vec_loader_if #(.NWORDS(NW), .nbits(32)) ifc ();
`ifdef PAGERANK_LOADER_PERF_EN
    logic [31:0] perf_cycles;
`endif

    pagerank_vec_loader #(.NWORDS(NW), .nbits(32)) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef PAGERANK_LOADER_PERF_EN
        .perf_cycles (perf_cycles),
`endif
        .ifc         (ifc)
    );

    typedef struct {
        logic [7:0]  opaque;
        logic [31:0] data;
        int          ready;
    } pend_t;

    logic [31:0] mem [logic [31:0]];
    pend_t       q0[$];
    pend_t       q1[$];
    logic [31:0] addr_log0[$];
    logic [31:0] addr_log1[$];
    int          cyc = 0;
    int          lat_max = 0;
    bit          hold0 = 1'b0;
    bit          rdy_random = 1'b0;
    int          n_p1_resp = 0;
    int          p1_expect = 0;
    int          n_resp = 0;
    int          n_bad_req = 0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void serve(input int port, input mem_req_msg_t m);
        pend_t e;
        if (m.typ == MEM_TYPE_WRITE) mem[m.addr] = m.data;
        if (m.typ != MEM_TYPE_READ || m.len != 2'd0) n_bad_req++;
        e.opaque = m.opaque;
        e.data   = mem.exists(m.addr) ? mem[m.addr] : 32'hDEAD_BEEF;
        e.ready  = cyc + 1 + int'($urandom_range(lat_max));
        if (port == 0) begin
            q0.push_back(e);
            addr_log0.push_back(m.addr);
        end else begin
            q1.push_back(e);
            addr_log1.push_back(m.addr);
        end
    endfunction

    // Memory: drive at the falling edge, then record the handshakes that the
    // next rising edge will complete.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            ifc.mem_resp0_val = 1'b0;
            ifc.mem_resp1_val = 1'b0;
            if (q0.size() > 0 && q0[0].ready <= cyc && !(hold0 && n_p1_resp < p1_expect)) begin
                ifc.mem_resp0_val = 1'b1;
                ifc.mem_resp0_msg = mem_resp_pack(MEM_TYPE_READ, q0[0].opaque, 2'd0, q0[0].data);
            end
            if (q1.size() > 0 && q1[0].ready <= cyc) begin
                ifc.mem_resp1_val = 1'b1;
                ifc.mem_resp1_msg = mem_resp_pack(MEM_TYPE_READ, q1[0].opaque, 2'd0, q1[0].data);
            end
            ifc.mem_req0_rdy = rdy_random ? ($urandom_range(3) != 0) : 1'b1;
            ifc.mem_req1_rdy = rdy_random ? ($urandom_range(3) != 0) : 1'b1;
            #1;
            if (ifc.mem_resp0_val && ifc.mem_resp0_rdy) begin
                void'(q0.pop_front());
                n_resp++;
            end
            if (ifc.mem_resp1_val && ifc.mem_resp1_rdy) begin
                void'(q1.pop_front());
                n_resp++;
                n_p1_resp++;
            end
            if (ifc.mem_req0_val && ifc.mem_req0_rdy) serve(0, ifc.mem_req0_msg);
            if (ifc.mem_req1_val && ifc.mem_req1_rdy) serve(1, ifc.mem_req1_msg);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic fill_mem(input logic [31:0] base, input bit seq);
        for (int i = 0; i < 2 * NW + 4; i++) begin
            mem[base + 32'(4 * i)] = seq ? 32'h10 + 32'(i) : ($urandom | 32'h1);
        end
    endtask

    task automatic do_load(input logic [31:0] base, input logic [31:0] count, input bit seq);
        logic [31:0] exp_vec [NW];
        int eff;
        int cycles;
        eff = (count > NW) ? NW : int'(count);
        fill_mem(base, seq);
        for (int i = 0; i < NW; i++) exp_vec[i] = (i < eff) ? mem[base + 32'(4 * i)] : 32'h0;
        addr_log0.delete();
        addr_log1.delete();
        n_bad_req = 0;
        n_p1_resp = 0;
        p1_expect = eff / 2;

        check("cmd_rdy_idle", 32'(ifc.cmd_rdy), 32'd1);
        ifc.cmd_base  = base;
        ifc.cmd_count = count;
        ifc.cmd_val   = 1'b1;
        tick();
        ifc.cmd_val = 1'b0;
        cycles = 0;
        while (!ifc.done_val && cycles < 1000) begin
            tick();
            cycles++;
        end
        check("done_val", 32'(ifc.done_val), 32'd1);
        if (count == 0) check("zero_count_latency", 32'(cycles), 32'd0);
        for (int i = 0; i < NW; i++) begin
            check($sformatf("vec[%0d] base=%h cnt=%0d", i, base, count), ifc.vec_data[32*i +: 32], exp_vec[i]);
        end
        check("p0_nreq", 32'(addr_log0.size()), 32'((eff + 1) / 2));
        check("p1_nreq", 32'(addr_log1.size()), 32'(eff / 2));
        for (int i = 0; i < addr_log0.size(); i++)
            check($sformatf("p0_addr[%0d]", i), addr_log0[i], base + 32'(8 * i));
        for (int i = 0; i < addr_log1.size(); i++)
            check($sformatf("p1_addr[%0d]", i), addr_log1[i], base + 32'(8 * i + 4));
        check("req_fields", 32'(n_bad_req), 32'd0);
`ifdef PAGERANK_LOADER_PERF_EN
        check("perf_cycles", perf_cycles, 32'(cycles));
`endif
        repeat (2) tick();
        check("done_hold", 32'(ifc.done_val), 32'd1);
        check("vec_stable", ifc.vec_data[31:0], exp_vec[0]);
        check("outstanding", 32'(q0.size() + q1.size()), 32'd0);
        ifc.done_rdy = 1'b1;
        tick();
        ifc.done_rdy = 1'b0;
        check("done_release", 32'(ifc.done_val), 32'd0);
        check("cmd_rdy_after", 32'(ifc.cmd_rdy), 32'd1);
        check("vec_kept", ifc.vec_data[31:0], exp_vec[0]);
    endtask

    initial begin
        int waited;
        reset         = 1'b1;
        ifc.cmd_val   = 1'b0;
        ifc.cmd_base  = '0;
        ifc.cmd_count = '0;
        ifc.done_rdy  = 1'b0;
        ifc.mem_req0_rdy  = 1'b0;
        ifc.mem_req1_rdy  = 1'b0;
        ifc.mem_resp0_val = 1'b0;
        ifc.mem_resp1_val = 1'b0;
        ifc.mem_resp0_msg = '0;
        ifc.mem_resp1_msg = '0;
        repeat (3) tick();

        check("rst_cmd_rdy", 32'(ifc.cmd_rdy), 32'd1);
        check("rst_done_val", 32'(ifc.done_val), 32'd0);
        check("rst_req_val", 32'({ifc.mem_req0_val, ifc.mem_req1_val}), 32'd0);
        check("rst_resp_rdy", 32'({ifc.mem_resp0_rdy, ifc.mem_resp1_rdy}), 32'd0);
        check("rst_vec_lo", ifc.vec_data[31:0], 32'd0);
        check("rst_vec_hi", ifc.vec_data[32*NW-1 -: 32], 32'd0);
        reset = 1'b0;
        tick();

        do_load(32'h0000_1000, 32'd8, 1'b1);
        do_load(32'h0000_2000, 32'd3, 1'b0);
        do_load(32'h0000_2800, 32'd0, 1'b0);

        lat_max = 4;
        hold0   = 1'b1;
        do_load(32'h0000_1000, 32'd8, 1'b1);
        hold0   = 1'b0;
        lat_max = 0;

        do_load(32'h0000_5000, 32'd20, 1'b0);

        // Reset part-way through an 8-word load.
        lat_max = 3;
        fill_mem(32'h0000_4000, 1'b0);
        n_resp = 0;
        ifc.cmd_base  = 32'h0000_4000;
        ifc.cmd_count = 32'd8;
        ifc.cmd_val   = 1'b1;
        tick();
        ifc.cmd_val = 1'b0;
        waited = 0;
        while (n_resp < 3 && waited < 500) begin
            tick();
            waited++;
        end
        check("mid_load_resp", 32'(n_resp >= 3), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q0.delete();
        q1.delete();
        check("mid_rst_cmd_rdy", 32'(ifc.cmd_rdy), 32'd1);
        check("mid_rst_done_val", 32'(ifc.done_val), 32'd0);
        for (int i = 0; i < NW; i++)
            check($sformatf("mid_rst_vec[%0d]", i), ifc.vec_data[32*i +: 32], 32'd0);
        lat_max = 0;
        do_load(32'h0000_3000, 32'd4, 1'b0);

        for (int t = 0; t < 12; t++) begin
            logic [31:0] base;
            base       = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            lat_max    = $urandom_range(4);
            rdy_random = 1'($urandom_range(1));
            hold0      = 1'($urandom_range(1));
            do_load(base, 32'($urandom_range(12)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
